// File: rtl/i2s_msb_deserializer_if.sv
// Bundle of the serial receive stream (from the ADAT receive channel's I2S
// transmitter) and the parallel sample stream handed to the USB packetiser.
interface i2s_msb_deserializer_if #(
  parameter int SAMPLE_BITS = 24
);
  logic                   i2s_bclk_i;
  logic                   i2s_lrclk_i;
  logic                   i2s_data_i;
  logic                   i2s_running_i;
  logic [SAMPLE_BITS-1:0] sample_o;
  logic [2:0]             channel_o;
  logic                   sample_valid_o;
  logic                   frame_done_o;
  logic                   locked_o;
  logic                   framing_error_o;
  logic [7:0]             error_count_o;

  // Stream source side: drives the serial lines, observes the samples.
  modport master (
    output i2s_bclk_i, i2s_lrclk_i, i2s_data_i, i2s_running_i,
    input  sample_o, channel_o, sample_valid_o, frame_done_o,
    input  locked_o, framing_error_o, error_count_o
  );

  // Deserializer side: consumes the serial lines, produces the samples.
  modport slave (
    input  i2s_bclk_i, i2s_lrclk_i, i2s_data_i, i2s_running_i,
    output sample_o, channel_o, sample_valid_o, frame_done_o,
    output locked_o, framing_error_o, error_count_o
  );
endinterface

// File: rtl/i2s_msb_deserializer.sv
// MSB-justified (left-justified) I2S/TDM deserializer. Samples data and LR on
// bit-clock rising edges detected in the system clock domain, rebuilds
// SAMPLE_BITS-wide samples per slot, tags them with the channel number and
// checks LR framing, resyncing in place on early edges and via SYNC on late
// edges.
module i2s_msb_deserializer #(
  parameter int SLOT_BITS      = 32,
  parameter int SAMPLE_BITS    = 24,
  parameter int SLOTS_PER_HALF = 4
) (
  input logic                   clk_i,
  input logic                   reset_i,
  i2s_msb_deserializer_if.slave bus
);

  localparam int BIT_W  = $clog2(SLOT_BITS);
  localparam int SLOT_W = $clog2(SLOTS_PER_HALF);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_HALF - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RECEIVE} state_t;

  state_t                 state, state_nxt;
  logic                   bclk_q;
  logic                   lr_q;
  logic [BIT_W-1:0]       bit_cnt, bit_nxt;
  logic [SLOT_W-1:0]      slot_cnt, slot_nxt;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic                   shift_en;
  logic                   emit;
  logic                   err;
  logic                   rise;
  logic                   half_start;
  logic                   last_bit;
  logic [SLOT_W:0]        channel_d;

  logic [SAMPLE_BITS-1:0] sample;
  logic [2:0]             channel;
  logic                   sample_valid;
  logic                   frame_done;
  logic                   framing_error;
  logic [7:0]             error_count;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rise       = bus.i2s_bclk_i & ~bclk_q;
  assign half_start = rise & (bus.i2s_lrclk_i != lr_q);
  // Counters sit on the last bit of the half: the only place an LR edge may land.
  assign last_bit   = (bit_cnt == LAST_BIT) && (slot_cnt == LAST_SLOT);
  assign channel_d  = {bus.i2s_lrclk_i, slot_cnt};

  // Bit-clock and LR history, tracked in every state so SYNC sees real edges
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bclk_q <= 1'b0;
      lr_q   <= 1'b0;
    end else begin
      bclk_q <= bus.i2s_bclk_i;
      if (rise) lr_q <= bus.i2s_lrclk_i;
    end
  end

  // State and slot-position registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_nxt;
      slot_cnt <= slot_nxt;
    end
  end

  // Next-state, counter advance, capture and framing decisions per rise
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    slot_nxt  = slot_cnt;
    shift_en  = 1'b0;
    emit      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i2s_running_i) state_nxt = SYNC;
      end
      SYNC: begin
        // Only a falling LR edge marks the start of channel 0.
        if (half_start && !bus.i2s_lrclk_i) begin
          state_nxt = RECEIVE;
          bit_nxt   = '0;
          slot_nxt  = '0;
          shift_en  = 1'b1;
        end
      end
      RECEIVE: begin
        if (half_start) begin
          // Any LR edge restarts the half; an early one drops the partial slot.
          bit_nxt  = '0;
          slot_nxt = '0;
          shift_en = 1'b1;
          err      = !last_bit;
        end else if (rise) begin
          if (last_bit) begin
            state_nxt = SYNC;
            err       = 1'b1;
          end else begin
            if (bit_cnt == LAST_BIT) begin
              bit_nxt  = '0;
              slot_nxt = slot_cnt + 1'b1;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
            shift_en = int'(bit_nxt) < SAMPLE_BITS;
            emit     = (bit_nxt == LAST_BIT);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Losing the transmitter overrides everything, including a slot completing now.
    if (!bus.i2s_running_i) begin
      state_nxt = IDLE;
      shift_en  = 1'b0;
      emit      = 1'b0;
      err       = 1'b0;
    end
  end

  // Sample shift register, MSB first, filled from the LSB side
  always_ff @(posedge clk_i) begin
    if (shift_en) shift_reg <= {shift_reg[SAMPLE_BITS-2:0], bus.i2s_data_i};
  end

  // Registered outputs: sample capture, strobes and saturating error count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sample        <= '0;
      channel       <= '0;
      sample_valid  <= 1'b0;
      frame_done    <= 1'b0;
      framing_error <= 1'b0;
      error_count   <= '0;
    end else begin
      sample_valid  <= emit;
      frame_done    <= emit && (channel_d == {1'b1, LAST_SLOT});
      framing_error <= err;
      if (emit) begin
        sample  <= shift_reg;
        channel <= 3'(channel_d);
      end
      if (err) error_count <= sat_inc(error_count);
    end
  end

  assign bus.sample_o        = sample;
  assign bus.channel_o       = channel;
  assign bus.sample_valid_o  = sample_valid;
  assign bus.frame_done_o    = frame_done;
  assign bus.framing_error_o = framing_error;
  assign bus.error_count_o   = error_count;
  assign bus.locked_o        = (state == RECEIVE);

endmodule

// File: doc/i2s_msb_deserializer.md
# i2s_msb_deserializer

Converts the MSB-justified serial stream from the ADAT receive channel (data, bit clock and LR clock, all generated in the system clock domain) back into parallel 24-bit samples tagged with an ADAT channel number. It sits directly downstream of the receive channel's I2S transmitter and feeds the USB packetiser. The block also checks framing and recovers from it.

## Interface
- SLOT_BITS, 32: bit clocks per channel slot.
- SAMPLE_BITS, 24: MSBs of each slot that are kept; the rest are ignored.
- SLOTS_PER_HALF, 4: slots per LR half. There are 2*SLOTS_PER_HALF channels in total.

- clk_i  in  1  system clock. All inputs are synchronous to it.
- reset_i  in  1  reset, asynchronous, active-high.
- i2s_bclk_i  in  1  bit clock, at most clk_i/2, high and low each at least 1 clk.
- i2s_lrclk_i  in  1  LR clock. Low selects channels 0..SLOTS_PER_HALF-1; high selects the upper channels.
- i2s_data_i  in  1  serial data, MSB first, valid at bclk rising edge.
- i2s_running_i  in  1  transmitter running flag.
- sample_o  out  SAMPLE_BITS  received sample.
- channel_o  out  3  channel index of sample_o.
- sample_valid_o  out  1  one-clk strobe; sample_o and channel_o are valid.
- frame_done_o  out  1  one-clk strobe with the valid of the last channel (channel 7).
- locked_o  out  1  high while the block is in RECEIVE.
- framing_error_o  out  1  one-clk strobe on a framing violation.
- error_count_o  out  8  saturating count of framing errors.

## Operation
- Edge detect:
  - bclk_q is a register of i2s_bclk_i.
  - rise = i2s_bclk_i & ~bclk_q.
  - All sampling of data and LR happens only on clocks where rise is high.
- At each rise:
  - lr_q is the previously sampled LR value.
  - A half starts when the sampled LR differs from lr_q.
  - Left-justified: the bit at the first rise of a half is the MSB of slot 0. There is no one-bit delay.
- Counters:
  - bit_cnt counts 0..SLOT_BITS-1.
  - slot_cnt counts 0..SLOTS_PER_HALF-1.
  - half_bits = bit_cnt + SLOT_BITS*slot_cnt.
  - At a half start, bit_cnt and slot_cnt load 0 and the MSB is shifted in.
- Shift register:
  - While bit_cnt < SAMPLE_BITS, data shifts into the SAMPLE_BITS register from the LSB side.
  - When bit_cnt == SLOT_BITS-1, the slot is complete.
  - On slot complete: sample_o <= shift register, channel_o <= {lr, slot_cnt[1:0]}, sample_valid_o pulses.
- FSM:
  - IDLE: all outputs are inactive. Move to SYNC when i2s_running_i = 1.
  - SYNC: wait for a half start with sampled LR = 0 (a falling LR edge). Then move to RECEIVE, treating that rise as bit 0 of channel 0. No samples are emitted in SYNC, and LR rising edges in SYNC are ignored.
  - RECEIVE: normal capture. locked_o = 1.
  - From any state, i2s_running_i = 0 goes to IDLE within 1 clk. A partial slot is discarded and no strobe is emitted.
- Framing errors (RECEIVE only):
  - Early edge: a half start while half_bits != SLOT_BITS*SLOTS_PER_HALF-1 at the previous rise. The partial slot is discarded. The new half is accepted as bit 0 (in-place resync) and the FSM stays in RECEIVE.
  - Late edge: the counter would pass the last bit of a half with no LR transition. The FSM goes to SYNC.
  - Either case pulses framing_error_o and increments error_count_o. The count saturates at 255 and is cleared only by reset.
- Simultaneous events: if the completion of slot 3 coincides with i2s_running_i falling, IDLE wins and no strobe is emitted.

## Timing
- Reset values:
  - sample_o = 0, channel_o = 0, error_count_o = 0.
  - All strobes = 0, locked_o = 0.
  - FSM = IDLE, bclk_q = 0, lr_q = 0.
- Latency: sample_valid_o is high in the clk immediately after the clk carrying the rise of the slot's last bit (bit SLOT_BITS-1). It lasts exactly 1 clk.
- sample_o and channel_o hold their values until the next strobe.
- locked_o:
  - Rises 1 clk after the rise that enters RECEIVE.
  - Falls 1 clk after the clk where running=0 is seen or a late-edge error is detected.
- framing_error_o is registered: it pulses 1 clk after the offending rise. error_count_o updates in the same clk as the pulse.
- An asynchronous reset mid-frame returns the block to IDLE immediately. No strobe is emitted afterwards until a full SYNC.

## Test plan
- Nominal frame: bclk = clk/4, 8 slots, with channel n carrying 0xA5_0000 | n. Expect 8 strobes with channel_o 0..7 and the matching samples, frame_done_o with channel 7, and error_count_o = 0.
- Lock-up: start the stream mid-frame with LR high. Expect no strobes until the first LR fall, then channel 0 is the first strobe and locked_o rises after that rise.
- Early LR edge: shorten the upper half by 5 bits. Expect one framing_error_o pulse, error_count_o = 1, locked_o still 1, and channel 0 of the next frame received correctly.
- Late LR edge: hold LR for 130 bits. Expect an error, locked_o to 0, and relock at the next LR fall.
- running_i dropped during slot 2: expect no strobe for slot 2, IDLE, and locked_o = 0 one clk later.
- Saturation: inject 300 early edges. Expect error_count_o = 255. Then assert reset mid-frame: expect all outputs at their reset values immediately.
